mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle main control FSM for the unpipelined MIPS core. It fetches through a req/ack memory port and sequences each instruction through decode, execute, memory and writeback states. It drives the datapath muxes and write enables. It also supplies the 6-bit ALU operation code consumed by `aluControl`, which continues to decode `i_func` from the instruction register directly.

## Interface
Parameters:
- `ILLEGAL_TRAP`, default 1: 1 = unknown opcode or function enters TRAP; 0 = treated as NOP and retired.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `i_func`  in  6  IR[5:0]; used only to detect JR and legal R-type functions.
- `i_zero`  in  1  ALU zero flag, combinational from the current ALU operation.
- `i_mem_ack`  in  1  memory transfer complete; sampled only while `o_mem_req`=1.
- `o_mem_req`  out  1  memory request; held high until ack.
- `o_mem_we`  out  1  write qualifier for `o_mem_req`.
- `o_iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `o_ir_we`  out  1  instruction register load.
- `o_mdr_we`  out  1  memory data register load.
- `o_pc_we`  out  1  PC load.
- `o_pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}, 11 rs.
- `o_alu_src_a`  out  1  0 = PC, 1 = rs.
- `o_alu_src_b`  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `o_alu_op`  out  6  opcode-style code to `aluControl`: 6'h08 = add, 6'h04 = sub, 6'h00 = R-type, otherwise `i_opcode`.
- `o_reg_we`, `o_reg_dst` (1 = rd), `o_mem_to_reg`  out  1 each  register file controls.
- `o_retire`  out  1  one-cycle pulse in the final cycle of each instruction.
- `o_trap`  out  1  sticky illegal-instruction flag.

## Operation
Reset values:
- State = IDLE; every output = 0.

States (outputs not listed are 0):
- IDLE: next state FETCH.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=08. While `i_mem_ack`=0, stay in FETCH. On ack: `ir_we`=1, `pc_we`=1, `pc_src`=00, next DECODE. The ack enables are Mealy outputs.
- DECODE: `alu_src_b`=11, `alu_op`=08; ALUOut latches the branch target. Dispatch:
  - R-type with legal func → EXEC_R; func 001000 → JR.
  - ADDI, ADDIU, ANDI, ORI, XORI, LUI → EXEC_I.
  - LW, SW → MEM_ADDR.
  - BEQ, BNE → BRANCH.
  - J → JUMP.
  - Anything else → TRAP (or retire as NOP when `ILLEGAL_TRAP`=0).
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00 → WB_R.
- WB_R: `reg_we`=1, `reg_dst`=1, retire → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=`i_opcode` → WB_I.
- WB_I: `reg_we`=1, `reg_dst`=0, retire → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=08. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_req`=1, `iord`=1. Wait for ack; on ack `mdr_we`=1 → WB_MEM.
- WB_MEM: `reg_we`=1, `mem_to_reg`=1, `reg_dst`=0, retire → FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. Wait for ack; on ack retire → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=04, `pc_src`=01. `pc_we` = `i_zero` for BEQ, ~`i_zero` for BNE. Retire → FETCH.
- JUMP: `pc_we`=1, `pc_src`=10, retire → FETCH.
- JR: `pc_we`=1, `pc_src`=11, retire → FETCH.
- TRAP: `o_trap`=1; all strobes 0; the state is terminal until `i_rst`.

## Timing
- Cycles per instruction at zero-wait memory (ack in the same cycle as req):
  - R-type and I-type ALU: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, BNE, J, JR: 3.
- Each memory wait cycle adds exactly one cycle.
- `o_mem_req` stays high continuously and the address select stays stable until ack. `i_mem_ack` outside a request state is ignored.
- `o_retire` is high for exactly one cycle per instruction. It is never asserted in IDLE or TRAP.
- `i_rst` during any state, including a pending memory request: at the next edge, state = IDLE and all outputs = 0. A pending request is abandoned, not completed.
- `i_rst` takes priority over a simultaneous `i_mem_ack`.

## Structure
- Package `mips_pkg`: opcode and function localparams (shared with `aluControl`), state encoding, `pc_src` codes, `alu_src_b` codes, ALU op codes 08/04/00.
- Sub-module `mc_dispatch`: combinational decode of opcode and func into the next state after DECODE, plus the legal-instruction flag.

## Test plan
- Reset, release, zero-wait memory: IDLE → FETCH → DECODE → ... with ADD (opcode 0, func 0x20). Expect `o_retire` in cycle 4 after FETCH entry and WB_R with `reg_we`=1, `reg_dst`=1.
- LW with ack delayed 2 cycles in both FETCH and MEM_RD: `mem_req` held throughout; `mdr_we` only in the ack cycle; retire after 9 cycles total.
- BEQ with `i_zero`=1 → `pc_we`=1, `pc_src`=01. BNE with `i_zero`=1 → `pc_we`=0. Both retire in cycle 3.
- JR (opcode 0, func 0x08) → `pc_src`=11 with `pc_we`=1. J → `pc_src`=10.
- Opcode 0x3F → TRAP, `o_trap`=1, no further `mem_req`. Assert `i_rst` → IDLE with `o_trap`=0.
- `i_rst` asserted in MEM_WR with `i_mem_ack`=1 on the same edge → next cycle IDLE with all outputs 0, and no retire pulse.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcode/function codes, control FSM states and mux codes
//            for the multi-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_ADDIU = 6'h09;
    localparam logic [5:0] C_OP_ANDI  = 6'h0C;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_XORI  = 6'h0E;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    localparam logic [5:0] C_FN_SLL  = 6'h00;
    localparam logic [5:0] C_FN_SRL  = 6'h02;
    localparam logic [5:0] C_FN_SRA  = 6'h03;
    localparam logic [5:0] C_FN_JR   = 6'h08;
    localparam logic [5:0] C_FN_ADD  = 6'h20;
    localparam logic [5:0] C_FN_ADDU = 6'h21;
    localparam logic [5:0] C_FN_SUB  = 6'h22;
    localparam logic [5:0] C_FN_SUBU = 6'h23;
    localparam logic [5:0] C_FN_AND  = 6'h24;
    localparam logic [5:0] C_FN_OR   = 6'h25;
    localparam logic [5:0] C_FN_XOR  = 6'h26;
    localparam logic [5:0] C_FN_NOR  = 6'h27;
    localparam logic [5:0] C_FN_SLT  = 6'h2A;
    localparam logic [5:0] C_FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [1:0] C_PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] C_PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] C_PC_SRC_RS     = 2'b11;

    localparam logic [1:0] C_ALUB_RT      = 2'b00;
    localparam logic [1:0] C_ALUB_FOUR    = 2'b01;
    localparam logic [1:0] C_ALUB_IMM     = 2'b10;
    localparam logic [1:0] C_ALUB_IMM_SH2 = 2'b11;

    localparam logic [5:0] C_ALUOP_ADD   = 6'h08;
    localparam logic [5:0] C_ALUOP_SUB   = 6'h04;
    localparam logic [5:0] C_ALUOP_RTYPE = 6'h00;

    // R-type functions implemented by aluControl (JR is handled separately).
    function automatic logic is_alu_func(input logic [5:0] func);
        case (func)
            C_FN_SLL, C_FN_SRL, C_FN_SRA,
            C_FN_ADD, C_FN_ADDU, C_FN_SUB, C_FN_SUBU,
            C_FN_AND, C_FN_OR, C_FN_XOR, C_FN_NOR,
            C_FN_SLT, C_FN_SLTU: is_alu_func = 1'b1;
            default:             is_alu_func = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : mc_dispatch
// Purpose  : Combinational decode of opcode/func into the state that follows
//            DECODE, plus a legal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
module mc_dispatch
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output state_t     o_next_state,
    output logic       o_legal
);

    always_comb begin
        o_next_state = S_TRAP;
        o_legal      = 1'b1;
        case (i_opcode)
            C_OP_RTYPE: begin
                if (i_func == C_FN_JR)
                    o_next_state = S_JR;
                else if (is_alu_func(i_func))
                    o_next_state = S_EXEC_R;
                else
                    o_legal = 1'b0;
            end
            C_OP_ADDI, C_OP_ADDIU, C_OP_ANDI,
            C_OP_ORI, C_OP_XORI, C_OP_LUI:  o_next_state = S_EXEC_I;
            C_OP_LW, C_OP_SW:               o_next_state = S_MEM_ADDR;
            C_OP_BEQ, C_OP_BNE:             o_next_state = S_BRANCH;
            C_OP_J:                         o_next_state = S_JUMP;
            default:                        o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle main control FSM: fetch, decode, execute, memory and
//            writeback sequencing with datapath mux/enable generation.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    input  logic       i_zero,
    input  logic       i_mem_ack,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_iord,
    output logic       o_ir_we,
    output logic       o_mdr_we,
    output logic       o_pc_we,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [5:0] o_alu_op,
    output logic       o_reg_we,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_retire,
    output logic       o_trap
);

    state_t r_state;
    state_t w_dispatch;
    logic   w_legal;
    logic   w_decode_ok;
    logic   w_ack;

    mc_dispatch u_dispatch (
        .i_opcode     (i_opcode),
        .i_func       (i_func),
        .o_next_state (w_dispatch),
        .o_legal      (w_legal)
    );

    // Reset wins over a coincident ack: the transfer is abandoned, not completed.
    assign w_ack       = i_mem_ack & ~i_rst;
    assign w_decode_ok = w_legal || ILLEGAL_TRAP;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     r_state <= S_FETCH;
                S_FETCH:    if (i_mem_ack) r_state <= S_DECODE;
                S_DECODE:   r_state <= w_decode_ok ? w_dispatch : S_FETCH;
                S_EXEC_R:   r_state <= S_WB_R;
                S_WB_R:     r_state <= S_FETCH;
                S_EXEC_I:   r_state <= S_WB_I;
                S_WB_I:     r_state <= S_FETCH;
                S_MEM_ADDR: r_state <= (i_opcode == C_OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (i_mem_ack) r_state <= S_WB_MEM;
                S_WB_MEM:   r_state <= S_FETCH;
                S_MEM_WR:   if (i_mem_ack) r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JUMP:     r_state <= S_FETCH;
                S_JR:       r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_we      = 1'b0;
        o_mdr_we     = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_src     = C_PC_SRC_ALU;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = C_ALUB_RT;
        o_alu_op     = C_ALUOP_RTYPE;
        o_reg_we     = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_retire     = 1'b0;
        o_trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = C_ALUB_FOUR;
                o_alu_op    = C_ALUOP_ADD;
                o_ir_we     = w_ack;
                o_pc_we     = w_ack;
            end
            S_DECODE: begin
                o_alu_src_b = C_ALUB_IMM_SH2;
                o_alu_op    = C_ALUOP_ADD;
                o_retire    = ~w_decode_ok;
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = C_ALUB_RT;
                o_alu_op    = C_ALUOP_RTYPE;
            end
            S_WB_R: begin
                o_reg_we  = 1'b1;
                o_reg_dst = 1'b1;
                o_retire  = 1'b1;
            end
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = C_ALUB_IMM;
                o_alu_op    = i_opcode;
            end
            S_WB_I: begin
                o_reg_we = 1'b1;
                o_retire = 1'b1;
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = C_ALUB_IMM;
                o_alu_op    = C_ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                o_mdr_we  = w_ack;
            end
            S_WB_MEM: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 1'b1;
                o_retire     = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_iord    = 1'b1;
                o_retire  = w_ack;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = C_ALUB_RT;
                o_alu_op    = C_ALUOP_SUB;
                o_pc_src    = C_PC_SRC_ALUOUT;
                o_pc_we     = (i_opcode == C_OP_BNE) ? ~i_zero : i_zero;
                o_retire    = 1'b1;
            end
            S_JUMP: begin
                o_pc_we  = 1'b1;
                o_pc_src = C_PC_SRC_JUMP;
                o_retire = 1'b1;
            end
            S_JR: begin
                o_pc_we  = 1'b1;
                o_pc_src = C_PC_SRC_RS;
                o_retire = 1'b1;
            end
            S_TRAP: begin
                o_trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Randomized scoreboard bench for mc_control with a memory
//            responder and a per-instruction reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    localparam logic [5:0] C_LW  = 6'h23;
    localparam logic [5:0] C_SW  = 6'h2B;
    localparam logic [5:0] C_BEQ = 6'h04;
    localparam logic [5:0] C_BNE = 6'h05;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ack;
    logic       o_mem_req, o_mem_we, o_iord, o_ir_we, o_mdr_we, o_pc_we;
    logic [1:0] o_pc_src;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [5:0] o_alu_op;
    logic       o_reg_we, o_reg_dst, o_mem_to_reg, o_retire, o_trap;

    always #5 clk = ~clk;

    mc_control #(.ILLEGAL_TRAP(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_opcode     (opcode),
        .i_func       (func),
        .i_zero       (zero),
        .i_mem_ack    (mem_ack),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_iord       (o_iord),
        .o_ir_we      (o_ir_we),
        .o_mdr_we     (o_mdr_we),
        .o_pc_we      (o_pc_we),
        .o_pc_src     (o_pc_src),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_alu_op     (o_alu_op),
        .o_reg_we     (o_reg_we),
        .o_reg_dst    (o_reg_dst),
        .o_mem_to_reg (o_mem_to_reg),
        .o_retire     (o_retire),
        .o_trap       (o_trap)
    );

    logic [21:0] all_outs;
    logic [11:0] mux_word;
    logic [7:0]  ctl_word;
    assign all_outs = {o_mem_req, o_mem_we, o_iord, o_ir_we, o_mdr_we, o_pc_we, o_pc_src,
                       o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_we, o_reg_dst,
                       o_mem_to_reg, o_retire, o_trap};
    assign mux_word = {o_alu_src_a, o_alu_src_b, o_alu_op, o_iord, o_pc_src};
    assign ctl_word = {o_mem_req, o_mem_we, o_reg_we, o_reg_dst, o_mem_to_reg, o_pc_we, o_pc_src};

    typedef struct {
        logic [5:0] op;
        int         cycles;
        logic [7:0] ctl;
        int         n_ir;
        int         n_mdr;
        int         n_pcwe;
        int         n_regwe;
        longint     sig;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mw(input logic a, input logic [1:0] b, input logic [5:0] op,
                                       input logic io, input logic [1:0] ps);
        return {a, b, op, io, ps};
    endfunction

    // Reference: cycle list per instruction class from the state table, CPI from the timing table.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input int fw, input int dw, input logic z);
        exp_t        e;
        logic [11:0] w[$];
        int          cpi;
        int          nd;
        logic        tk;
        e.op = op; e.n_ir = 1; e.n_pcwe = 1; e.n_mdr = 0; e.n_regwe = 0; e.ctl = 8'h00;
        nd = 0; cpi = 3;
        for (int i = 0; i <= fw; i++) w.push_back(mw(1'b0, 2'b01, 6'h08, 1'b0, 2'b00));
        w.push_back(mw(1'b0, 2'b11, 6'h08, 1'b0, 2'b00));
        if (op == 6'h00 && fn == 6'h08) begin
            cpi = 3; e.ctl = 8'b0000_0111; e.n_pcwe = 2;
            w.push_back(mw(1'b0, 2'b00, 6'h00, 1'b0, 2'b11));
        end else if (op == 6'h00) begin
            cpi = 4; e.ctl = 8'b0011_0000; e.n_regwe = 1;
            w.push_back(mw(1'b1, 2'b00, 6'h00, 1'b0, 2'b00));
            w.push_back(12'h000);
        end else begin
            case (op)
                6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    cpi = 4; e.ctl = 8'b0010_0000; e.n_regwe = 1;
                    w.push_back(mw(1'b1, 2'b10, op, 1'b0, 2'b00));
                    w.push_back(12'h000);
                end
                C_LW: begin
                    cpi = 5; nd = dw; e.ctl = 8'b0010_1000; e.n_regwe = 1; e.n_mdr = 1;
                    w.push_back(mw(1'b1, 2'b10, 6'h08, 1'b0, 2'b00));
                    for (int i = 0; i <= dw; i++) w.push_back(mw(1'b0, 2'b00, 6'h00, 1'b1, 2'b00));
                    w.push_back(12'h000);
                end
                C_SW: begin
                    cpi = 4; nd = dw; e.ctl = 8'b1100_0000;
                    w.push_back(mw(1'b1, 2'b10, 6'h08, 1'b0, 2'b00));
                    for (int i = 0; i <= dw; i++) w.push_back(mw(1'b0, 2'b00, 6'h00, 1'b1, 2'b00));
                end
                C_BEQ, C_BNE: begin
                    cpi = 3;
                    tk = (op == C_BEQ) ? z : ~z;
                    e.ctl = {5'b00000, tk, 2'b01};
                    e.n_pcwe = 1 + int'(tk);
                    w.push_back(mw(1'b1, 2'b00, 6'h04, 1'b0, 2'b01));
                end
                default: begin
                    cpi = 3; e.ctl = 8'b0000_0110; e.n_pcwe = 2;
                    w.push_back(mw(1'b0, 2'b00, 6'h00, 1'b0, 2'b10));
                end
            endcase
        end
        e.cycles = cpi + fw + nd;
        e.sig = 0;
        for (int i = 0; i < w.size(); i++) e.sig += longint'(i + 1) * longint'(w[i]);
        return e;
    endfunction

    // Monitor: accumulates per-instruction activity and checks it on each retire.
    int     cnt = -1;
    int     a_ir = 0, a_mdr = 0, a_pcwe = 0, a_regwe = 0;
    longint a_sig = 0;
    logic   pend = 1'b0, pend_iord = 1'b0, prev_rst = 1'b0;
    exp_t   e;

    always @(negedge clk) begin
        if (prev_rst) chk("reset_outputs", longint'(all_outs), 0);
        if (rst) begin
            sb.delete();
            cnt = -1; a_ir = 0; a_mdr = 0; a_pcwe = 0; a_regwe = 0; a_sig = 0; pend = 1'b0;
        end else begin
            cnt++;
            if (pend) chk("req_held", longint'({o_mem_req, o_iord}), longint'({1'b1, pend_iord}));
            pend      = o_mem_req & ~mem_ack;
            pend_iord = o_iord;
            a_ir    += int'(o_ir_we);
            a_mdr   += int'(o_mdr_we);
            a_pcwe  += int'(o_pc_we);
            a_regwe += int'(o_reg_we);
            a_sig   += longint'(cnt) * longint'(mux_word);
            if (o_retire) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("cycles op%0h", e.op), cnt, e.cycles);
                    chk($sformatf("retire_ctl op%0h", e.op), longint'(ctl_word), longint'(e.ctl));
                    chk($sformatf("ir_we_cnt op%0h", e.op), a_ir, e.n_ir);
                    chk($sformatf("mdr_we_cnt op%0h", e.op), a_mdr, e.n_mdr);
                    chk($sformatf("pc_we_cnt op%0h", e.op), a_pcwe, e.n_pcwe);
                    chk($sformatf("reg_we_cnt op%0h", e.op), a_regwe, e.n_regwe);
                    chk($sformatf("mux_sig op%0h", e.op), a_sig, e.sig);
                end
                cnt = 0; a_ir = 0; a_mdr = 0; a_pcwe = 0; a_regwe = 0; a_sig = 0;
            end
        end
        prev_rst = rst;
    end

    // Memory responder: idle cycles get random ack noise, which must be ignored.
    task automatic wait_req(input logic want_iord, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b1;
        while (!(o_mem_req === 1'b1 && o_iord === want_iord)) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
            if (guard > 40) begin
                chk("req_timeout", 0, 1);
                ok = 1'b0;
                mem_ack = 1'b0;
                return;
            end
        end
    endtask

    // mode 0: full instruction; 1: fetch only, expectation pushed; 2: fetch only, nothing expected
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw,
                         input logic z, input int mode);
        bit ok;
        wait_req(1'b0, ok);
        if (!ok) return;
        repeat (fw) begin mem_ack = 1'b0; @(posedge clk); #1; end
        mem_ack = 1'b1;
        if (mode != 2) sb.push_back(model(op, fn, fw, dw, z));
        @(posedge clk); #1;
        mem_ack = 1'b0; opcode = op; func = fn; zero = z;
        if (mode == 0 && (op == C_LW || op == C_SW)) begin
            wait_req(1'b1, ok);
            if (!ok) return;
            repeat (dw) begin mem_ack = 1'b0; @(posedge clk); #1; end
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
    endtask

    logic [5:0] pool_op [0:17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09,
                                   6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    logic [5:0] pool_fn [0:6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k, fw, dw;
        logic [5:0] fn;
        bit         ok;
        rst = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(6'h00, 6'h20, 0, 0, 1'b0, 0);   // ADD, zero wait
        issue(C_LW, 6'h11, 2, 2, 1'b0, 0);    // LW, 2 wait cycles each side
        issue(C_BEQ, 6'h00, 0, 0, 1'b1, 0);
        issue(C_BNE, 6'h00, 0, 0, 1'b1, 0);
        issue(6'h00, 6'h08, 0, 0, 1'b0, 0);   // JR
        issue(6'h02, 6'h15, 0, 0, 1'b0, 0);   // J
        issue(C_SW, 6'h00, 1, 3, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(0, 17);
            fn = (k < 7) ? pool_fn[k] : 6'($urandom_range(0, 63));
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            dw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            issue(pool_op[k], fn, fw, dw, 1'($urandom_range(0, 1)), 0);
        end

        for (int g = 0; g < 60 && sb.size() != 0; g++) begin @(posedge clk); #1; end
        chk("sb_drain", sb.size(), 0);

        // Reset arriving with the store's ack: abandoned, no retire.
        issue(C_SW, 6'h00, 0, 0, 1'b0, 1);
        wait_req(1'b1, ok);
        mem_ack = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_vs_ack_retire", longint'(o_retire), 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b0;

        // Illegal opcode: trap is terminal until reset.
        issue(6'h3F, 6'h00, 0, 0, 1'b0, 2);
        for (int i = 0; i < 8; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i > 0) chk("trap_state", longint'({o_trap, o_mem_req, o_retire}), 4);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("trap_cleared", longint'(o_trap), 0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
